branch_predictor: RTL and testbench

Fetch-stage branch predictor for the pipelined RV32I core: a direct-mapped branch target buffer plus a table of 2-bit saturating counters, looked up combinationally with the IF-stage PC to produce a predicted next PC. It is the counterpart of the ID-stage branch-condition evaluator. That evaluator resolves whether a branch is taken. This block consumes that resolution, trains on it, and reports mispredicts so the hazard unit can flush.

---
 rtl/branch_predictor_pkg.sv | 16 +
 rtl/branch_predictor_sat_counter2.sv | 25 ++
 rtl/branch_predictor.sv | 143 ++++++++++++++
 tb/tb_branch_predictor.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-stage branch predictor: 2-bit counter
// encodings and default table/history sizes.
package branch_predictor_pkg;

    // Pattern-table counter encodings
    typedef enum logic [1:0] {
        SNT = 2'b00,  // strongly not taken
        WNT = 2'b01,  // weakly not taken (reset value)
        WT  = 2'b10,  // weakly taken
        ST  = 2'b11   // strongly taken
    } cnt_state_e;

    localparam int BTB_ENTRIES_DEF = 32;
    localparam int GHR_BITS_DEF    = 5;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// sat_counter2: next-state function of one 2-bit saturating counter.
// force_st wins over inc, inc over dec; with none asserted the value holds.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cnt_i,
    input  logic       inc,
    input  logic       dec,
    input  logic       force_st,
    output logic [1:0] cnt_o
);

    // Saturating step; ST and SNT are sticky in their direction
    always_comb begin
        cnt_o = cnt_i;
        if (force_st) begin
            cnt_o = ST;
        end else if (inc) begin
            if (cnt_i != ST) cnt_o = cnt_i + 2'd1;
        end else if (dec) begin
            if (cnt_i != SNT) cnt_o = cnt_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB plus 2-bit counter PHT, looked up
// combinationally with the IF PC and trained by resolved control flow.
// Optional feature: define BP_GSHARE_EN to index the PHT with PC XOR global
// history (gshare); undefined gives a bimodal table with no history register.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int BTB_ENTRIES = BTB_ENTRIES_DEF,
    parameter int GHR_BITS    = GHR_BITS_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         fetch_pc,
    output logic                pred_taken,
    output logic [31:0]         pred_next_pc,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                update_valid,
    input  logic                update_is_cond,
    input  logic [31:0]         update_pc,
    input  logic                update_taken,
    input  logic [31:0]         update_target,
    input  logic                update_pred_taken,
    input  logic [31:0]         update_pred_target,
    input  logic [GHR_BITS-1:0] update_ghr,
    output logic                mispredict,
    output logic [31:0]         branch_count,
    output logic [31:0]         mispredict_count
);

    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX;

    // Table state
    logic [BTB_ENTRIES-1:0]             btb_valid_q, btb_valid_d;
    logic [BTB_ENTRIES-1:0][TAG_W-1:0]  btb_tag_q, btb_tag_d;
    logic [BTB_ENTRIES-1:0][31:0]       btb_target_q, btb_target_d;
    logic [BTB_ENTRIES-1:0][1:0]        pht_q, pht_d;
    logic [31:0]                        branch_count_q, branch_count_d;
    logic [31:0]                        mispredict_count_q, mispredict_count_d;

    logic [IDX-1:0]   f_idx, f_pidx, u_idx, u_pidx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             hit;
    logic [1:0]       cnt_next;

    assign f_idx = fetch_pc[IDX+1:2];
    assign f_tag = fetch_pc[31:IDX+2];
    assign u_idx = update_pc[IDX+1:2];
    assign u_tag = update_pc[31:IDX+2];

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    logic                unused_bits;

    // Non-speculative history: only resolved conditional branches shift in
    always_comb begin
        ghr_d = ghr_q;
        if (update_valid && update_is_cond)
            ghr_d = GHR_BITS'({ghr_q, update_taken});
    end

    // History register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ghr_q <= '0;
        else        ghr_q <= ghr_d;
    end

    // Training uses the history the lookup saw, never the live one
    assign f_pidx   = f_idx ^ IDX'(ghr_q);
    assign u_pidx   = u_idx ^ IDX'(update_ghr);
    assign pred_ghr = ghr_q;
    assign unused_bits = ^{fetch_pc[1:0], update_pc[1:0]};
`else
    logic unused_bits;

    assign f_pidx   = f_idx;
    assign u_pidx   = u_idx;
    assign pred_ghr = '0;
    assign unused_bits = ^{fetch_pc[1:0], update_pc[1:0], update_ghr};
`endif

    // Lookup sees only registered state, so a same-cycle update is invisible
    assign hit          = btb_valid_q[f_idx] && (btb_tag_q[f_idx] == f_tag);
    assign pred_taken   = hit && pht_q[f_pidx][1];
    assign pred_next_pc = pred_taken ? btb_target_q[f_idx] : fetch_pc + 32'd4;

    // Wrong direction, or right "taken" direction to the wrong place
    assign mispredict = update_valid &&
                        ((update_taken != update_pred_taken) ||
                         (update_taken && (update_target != update_pred_target)));

    // One counter step per update; jumps pin the counter at strongly taken
    sat_counter2 u_sat_counter2 (
        .cnt_i    (pht_q[u_pidx]),
        .inc      (update_is_cond && update_taken),
        .dec      (update_is_cond && !update_taken),
        .force_st (!update_is_cond),
        .cnt_o    (cnt_next)
    );

    // Next-state for tables and statistics
    always_comb begin
        btb_valid_d        = btb_valid_q;
        btb_tag_d          = btb_tag_q;
        btb_target_d       = btb_target_q;
        pht_d              = pht_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (update_valid) begin
            if (update_taken) begin
                btb_valid_d[u_idx]  = 1'b1;
                btb_tag_d[u_idx]    = u_tag;
                btb_target_d[u_idx] = update_target;
            end
            pht_d[u_pidx]  = cnt_next;
            branch_count_d = branch_count_q + 32'd1;
            if (mispredict) mispredict_count_d = mispredict_count_q + 32'd1;
        end
    end

    // State registers; reset discards any update pending on the same edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btb_valid_q        <= '0;
            btb_tag_q          <= '0;
            btb_target_q       <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) pht_q[i] <= WNT;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            btb_valid_q        <= btb_valid_d;
            btb_tag_q          <= btb_tag_d;
            btb_target_q       <= btb_target_d;
            pht_q              <= pht_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (default bimodal build, 32 entries).
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_next_pc;
    logic [4:0]  pred_ghr;
    logic        update_valid, update_is_cond, update_taken, update_pred_taken;
    logic [31:0] update_pc, update_target, update_pred_target;
    logic [4:0]  update_ghr;
    logic        mispredict;
    logic [31:0] branch_count, mispredict_count;

    int checks = 0;
    int errors = 0;

    branch_predictor #(.BTB_ENTRIES(32), .GHR_BITS(5)) dut (
        .clk                (clk),
        .reset              (reset),
        .fetch_pc           (fetch_pc),
        .pred_taken         (pred_taken),
        .pred_next_pc       (pred_next_pc),
        .pred_ghr           (pred_ghr),
        .update_valid       (update_valid),
        .update_is_cond     (update_is_cond),
        .update_pc          (update_pc),
        .update_taken       (update_taken),
        .update_target      (update_target),
        .update_pred_taken  (update_pred_taken),
        .update_pred_target (update_pred_target),
        .update_ghr         (update_ghr),
        .mispredict         (mispredict),
        .branch_count       (branch_count),
        .mispredict_count   (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic cond, input logic [31:0] pc, input logic tk,
                           input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        update_valid       = 1'b1;
        update_is_cond     = cond;
        update_pc          = pc;
        update_taken       = tk;
        update_target      = tgt;
        update_pred_taken  = ptk;
        update_pred_target = ptgt;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] npc);
        fetch_pc = pc;
        #1;
        check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, tk});
        check({tag, "_npc"}, pred_next_pc, npc);
    endtask

    initial begin
        reset = 1'b0;
        fetch_pc = 32'h100;
        update_valid = 1'b0; update_is_cond = 1'b0; update_pc = '0; update_taken = 1'b0;
        update_target = '0; update_pred_taken = 1'b0; update_pred_target = '0; update_ghr = '0;
        #1;
        // Reset state
        look("rst_lookup", 32'h100, 1'b0, 32'h104);
        check("rst_ghr", {27'd0, pred_ghr}, 32'd0);
        check("rst_bc", branch_count, 32'd0);
        check("rst_mc", mispredict_count, 32'd0);
        check("rst_mp_idle", {31'd0, mispredict}, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // U1: taken at 0x100 predicted not-taken -> WT
        set_upd(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        #1 check("u1_mp", {31'd0, mispredict}, 32'd1);
        tick(); update_valid = 1'b0;
        check("u1_bc", branch_count, 32'd1);
        check("u1_mc", mispredict_count, 32'd1);
        look("u1_lookup", 32'h100, 1'b1, 32'h80);

        // U2: not taken, predicted taken -> WNT
        set_upd(1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        #1 check("u2_mp", {31'd0, mispredict}, 32'd1);
        tick(); update_valid = 1'b0;
        look("u2_lookup", 32'h100, 1'b0, 32'h104);

        // U3: not taken, correctly predicted -> SNT
        set_upd(1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
        #1 check("u3_mp", {31'd0, mispredict}, 32'd0);
        tick(); update_valid = 1'b0;
        look("u3_lookup", 32'h100, 1'b0, 32'h104);

        // U4: not taken again, SNT holds (a wrap would predict taken)
        set_upd(1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
        tick(); update_valid = 1'b0;
        look("u4_sat", 32'h100, 1'b0, 32'h104);
        check("u4_bc", branch_count, 32'd4);
        check("u4_mc", mispredict_count, 32'd2);

        // U5/U6: two taken steps SNT->WNT->WT; BTB entry still there
        set_upd(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        tick();
        look("u5_lookup", 32'h100, 1'b0, 32'h104);
        tick(); update_valid = 1'b0;
        look("u6_lookup", 32'h100, 1'b1, 32'h80);
        check("u6_mc", mispredict_count, 32'd4);

        // J1: JAL at 0x200 -> ST, predicts 0x400
        set_upd(1'b0, 32'h200, 1'b1, 32'h400, 1'b0, 32'h204);
        #1 check("j1_mp", {31'd0, mispredict}, 32'd1);
        tick(); update_valid = 1'b0;
        look("j1_lookup", 32'h200, 1'b1, 32'h400);

        // Direction right, target wrong -> mispredict; both right -> none
        set_upd(1'b0, 32'h200, 1'b1, 32'h400, 1'b1, 32'h500);
        #1 check("tgt_mp", {31'd0, mispredict}, 32'd1);
        update_pred_target = 32'h400;
        #1 check("ok_mp", {31'd0, mispredict}, 32'd0);
        tick(); update_valid = 1'b0;
        #1 check("novalid_mp", {31'd0, mispredict}, 32'd0);
        check("j2_bc", branch_count, 32'd8);
        check("j2_mc", mispredict_count, 32'd5);

        // Alias: 0x180 shares index 0 with 0x100 and replaces it
        set_upd(1'b1, 32'h180, 1'b1, 32'h900, 1'b0, 32'h184);
        tick(); update_valid = 1'b0;
        look("alias_old", 32'h100, 1'b0, 32'h104);
        look("alias_new", 32'h180, 1'b1, 32'h900);

        // Same-cycle lookup and update at 0x300: old view now, new next cycle
        fetch_pc = 32'h300;
        set_upd(1'b0, 32'h300, 1'b1, 32'h700, 1'b0, 32'h304);
        look("same_before", 32'h300, 1'b0, 32'h304);
        tick(); update_valid = 1'b0;
        look("same_after", 32'h300, 1'b1, 32'h700);
        check("same_bc", branch_count, 32'd10);
        check("same_mc", mispredict_count, 32'd7);

        // Reset mid-update: state clears at once, pending update dropped
        set_upd(1'b1, 32'h200, 1'b1, 32'h600, 1'b1, 32'h400);
        #1 reset = 1'b0;
        #1;
        check("rst_mid_bc", branch_count, 32'd0);
        check("rst_mid_mc", mispredict_count, 32'd0);
        check("rst_mid_mp", {31'd0, mispredict}, 32'd1);
        look("rst_mid_300", 32'h300, 1'b0, 32'h304);
        tick();
        update_valid = 1'b0;
        reset = 1'b1;
        #1;
        look("rst_after_200", 32'h200, 1'b0, 32'h204);
        check("rst_after_bc", branch_count, 32'd0);
        check("rst_after_ghr", {27'd0, pred_ghr}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
